// File: rtl/johnson_decoder_monitor.sv
// johnson_decoder_monitor
//  Receive-side decoder and integrity checker for a WIDTH-bit Johnson
//  (twisted-ring) counter. Each qualified sample is decoded to a binary
//  index, checked for legality and for following the counter's sequence.
//  A HUNT/CHECK/LOCKED FSM tracks sync, and a saturating counter tallies errors.
//  Optional feature macro: JCDEC_ERR_CLR_EN adds a synchronous err_clr input.
module johnson_decoder_monitor #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = 3,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             jc_valid,
`ifdef JCDEC_ERR_CLR_EN
  input  logic             err_clr,
`endif
  output logic [IDX_W-1:0] bin_out,
  output logic             code_ok,
  output logic             seq_ok,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int RUN_W   = $clog2(LOCK_CNT + 1);
  localparam int NSTATES = 2 * WIDTH;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic             code_ok_q, code_ok_d;
  logic             seq_ok_q, seq_ok_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming code
  // ---------------------------------------------------------------------
  // Pairwise monotonicity: a legal code with LSB=0 never has a 1 below a 0
  // (ones packed at the MSB end); with LSB=1 it never has a 0 below a 1.
  logic [WIDTH-2:0] ones_hi_ok;
  logic [WIDTH-2:0] zeros_hi_ok;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_mono
      assign ones_hi_ok[gi]  = jc_in[gi+1] | ~jc_in[gi];
      assign zeros_hi_ok[gi] = jc_in[gi]   | ~jc_in[gi+1];
    end
  endgenerate

  logic [IDX_W-1:0] ones_cnt;
  logic             code_legal;
  logic [IDX_W-1:0] code_idx;
  logic [IDX_W-1:0] prev_succ;
  logic             is_adv;
  logic             is_rep;

  // Population count of the code, then map to index (k ones, or WIDTH+zeros).
  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (jc_in[i]) ones_cnt = ones_cnt + IDX_W'(1);
    end
    code_legal = jc_in[0] ? (&zeros_hi_ok) : (&ones_hi_ok);
    // WIDTH + zeros == 2*WIDTH - ones; modular wrap keeps it in range.
    code_idx   = jc_in[0] ? (IDX_W'(NSTATES) - ones_cnt) : ones_cnt;
    prev_succ  = (prev_q == IDX_W'(NSTATES - 1)) ? '0 : prev_q + IDX_W'(1);
    is_adv     = (code_idx == prev_succ);
    is_rep     = (code_idx == prev_q);
  end

  // ---------------------------------------------------------------------
  // Next-state: lock FSM, sequence tracking and error accounting
  // ---------------------------------------------------------------------
  logic             count_err;
  logic [RUN_W-1:0] run_inc;

  // Evaluate one qualified sample; everything holds when jc_valid is low.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    bin_d       = bin_q;
    code_ok_d   = code_ok_q;
    seq_ok_d    = seq_ok_q;
    err_cnt_d   = err_cnt_q;
    count_err   = 1'b0;
    run_inc     = run_q + RUN_W'(1);

    if (jc_valid) begin
      if (!code_legal) begin
        // Illegal code: always an error, never also a sequence error.
        code_ok_d = 1'b0;
        seq_ok_d  = 1'b0;
        count_err = 1'b1;
        state_d   = HUNT;
        run_d     = '0;
      end else begin
        bin_d     = code_idx;
        code_ok_d = 1'b1;
        prev_d    = code_idx;
        case (state_q)
          HUNT: begin
            // First legal code only seeds the tracker; it cannot be judged.
            state_d  = CHECK;
            run_d    = RUN_W'(1);
            seq_ok_d = 1'b0;
          end
          CHECK, LOCKED: begin
            if (is_adv) begin
              seq_ok_d = 1'b1;
              if (state_q == CHECK) begin
                run_d = run_inc;
                if (run_inc == RUN_W'(LOCK_CNT)) state_d = LOCKED;
              end
            end else if (is_rep) begin
              seq_ok_d = 1'b1;
            end else begin
              seq_ok_d  = 1'b0;
              count_err = 1'b1;
              state_d   = HUNT;
              run_d     = '0;
            end
          end
          default: begin
            state_d = HUNT;
            run_d   = '0;
          end
        endcase
      end
    end

    err_pulse_d = count_err;
    if (count_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef JCDEC_ERR_CLR_EN
    // Clear beats a simultaneous error; the pulse still reports it.
    if (err_clr) err_cnt_d = '0;
`endif
  end

  // ---------------------------------------------------------------------
  // State and output registers, asynchronously cleared
  // ---------------------------------------------------------------------
  // Register all state and outputs; reset low clears immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      run_q       <= '0;
      bin_q       <= '0;
      code_ok_q   <= 1'b0;
      seq_ok_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      bin_q       <= bin_d;
      code_ok_q   <= code_ok_d;
      seq_ok_q    <= seq_ok_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign code_ok   = code_ok_q;
  assign seq_ok    = seq_ok_q;
  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule
